// File: rtl/sdram_read_burst.sv
// SDRAM burst read engine: ACT/RD/PRE sequencing via arbiter grant, refresh yield, row/bank crossing.
// Latency: first rd_data_vld CAS_LAT+1 cycles after the RD command appears on rd_cmd.
// Backpressure: none on read data; bus access waits on rd_en, ref_req yields at burst end. Option: RD_AUTO_PRE_EN.
module sdram_read_burst #(
    parameter int ROW_W     = 12,
    parameter int COL_W     = 9,
    parameter int BANK_W    = 2,
    parameter int DQ_W      = 16,
    parameter int BURST_LEN = 4,
    parameter int CAS_LAT   = 3,
    parameter int TRCD      = 3,
    parameter int TRP       = 3,
    parameter int LEN_W     = 16
) (
    input  logic                          sclk,
    input  logic                          s_rst_n,
    input  logic                          rd_trig,
    input  logic [BANK_W+ROW_W+COL_W-1:0] rd_start_addr,
    input  logic [LEN_W-1:0]              rd_len,
    output logic                          rd_busy,
    output logic                          rd_done,
    output logic                          rd_req,
    input  logic                          rd_en,
    input  logic                          ref_req,
    output logic                          flag_rd_end,
    output logic [3:0]                    rd_cmd,
    output logic [ROW_W-1:0]              rd_addr,
    output logic [BANK_W-1:0]             bank_addr,
    input  logic [DQ_W-1:0]               sdram_dq_in,
    output logic [DQ_W-1:0]               rd_data,
    output logic                          rd_data_vld
);

    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam logic [ADDR_W-1:0] BL_STEP   = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BURST_LEN - 1);
    localparam logic [7:0]        BL_LAST   = 8'(BURST_LEN - 1);
    localparam logic [7:0]        TRCD_LAST = 8'(TRCD - 1);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    typedef enum logic [2:0] {IDLE, REQ, ACT, RD, PRE} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr, addr_nxt, addr_post;
    logic [LEN_W-1:0]  rem, rem_nxt, rem_post;
    logic [7:0]        cnt, cnt_nxt, pre_last;
    logic              ref_seen, ref_seen_nxt;
    logic              ap_q, ap_q_nxt, ap, ap_now;
    logic              wrap_post, accept;

    logic [3:0]        cmd_nxt;
    logic [ROW_W-1:0]  raddr_nxt;
    logic [BANK_W-1:0] bank_nxt;
    logic              flag_nxt, in_rd_nxt, last_nxt;

    logic               in_rd_q, last_q;
    logic [CAS_LAT-1:0] vld_pipe, last_pipe;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;

    assign col  = addr[COL_W-1:0];
    assign row  = addr[COL_W +: ROW_W];
    assign bank = addr[COL_W+ROW_W +: BANK_W];

    // Address and count advance on the RD cycle; these give the post-RD view at any burst count.
    assign addr_post = (cnt == '0) ? addr + BL_STEP : addr;
    assign rem_post  = (cnt == '0) ? rem - LEN_W'(1) : rem;
    assign wrap_post = (addr_post[COL_W-1:0] == '0);
    assign ap_now    = (cnt == '0) ? ap : ap_q;

`ifdef RD_AUTO_PRE_EN
    assign ap       = (rem_post == '0) || wrap_post || ref_req;
    assign pre_last = ap_q ? 8'(BURST_LEN + TRP - 2) : 8'(TRP - 1);
`else
    assign ap       = 1'b0;
    assign pre_last = 8'(TRP - 1);
`endif

    assign rd_req = (state == REQ);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        addr_nxt     = addr;
        rem_nxt      = rem;
        ref_seen_nxt = ref_seen;
        ap_q_nxt     = ap_q;
        cmd_nxt      = CMD_NOP;
        raddr_nxt    = '0;
        bank_nxt     = '0;
        flag_nxt     = 1'b0;
        in_rd_nxt    = 1'b0;
        last_nxt     = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (rd_trig && (rd_len != '0) && !rd_busy) begin
                    accept    = 1'b1;
                    addr_nxt  = rd_start_addr & ADDR_MASK;
                    rem_nxt   = rd_len;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (rd_en) begin
                    state_nxt = ACT;
                    cnt_nxt   = '0;
                end
            end
            ACT: begin
                if (cnt == '0) begin
                    cmd_nxt   = CMD_ACT;
                    raddr_nxt = row;
                    bank_nxt  = bank;
                end
                if (cnt == TRCD_LAST) begin
                    state_nxt = RD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            RD: begin
                in_rd_nxt = 1'b1;
                if (cnt == '0) begin
                    cmd_nxt       = CMD_RD;
                    raddr_nxt     = ROW_W'(col);
                    raddr_nxt[10] = ap;
                    bank_nxt      = bank;
                    addr_nxt      = addr + BL_STEP;
                    rem_nxt       = rem - LEN_W'(1);
                    ap_q_nxt      = ap;
                end
                if (cnt == BL_LAST) begin
                    last_nxt = (rem_post == '0);
                    cnt_nxt  = '0;
                    // Refresh is only honoured here, so a burst is never cut short.
                    if ((rem_post == '0) || wrap_post || ref_req || ap_now) begin
                        state_nxt    = PRE;
                        ref_seen_nxt = ref_req;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            PRE: begin
                if ((cnt == '0) && !ap_q) begin
                    cmd_nxt       = CMD_PRE;
                    raddr_nxt[10] = 1'b1;
                    bank_nxt      = bank;
                end
                if (cnt == pre_last) begin
                    cnt_nxt = '0;
                    if (rem == '0) begin
                        state_nxt = IDLE;
                        flag_nxt  = 1'b1;
                    end else if (ref_seen || ref_req) begin
                        state_nxt = REQ;
                        flag_nxt  = 1'b1;
                    end else begin
                        state_nxt = ACT;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            addr     <= '0;
            rem      <= '0;
            ref_seen <= 1'b0;
            ap_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            addr     <= addr_nxt;
            rem      <= rem_nxt;
            ref_seen <= ref_seen_nxt;
            ap_q     <= ap_q_nxt;
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rd_cmd      <= CMD_NOP;
            rd_addr     <= '0;
            bank_addr   <= '0;
            flag_rd_end <= 1'b0;
            in_rd_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            rd_cmd      <= cmd_nxt;
            rd_addr     <= raddr_nxt;
            bank_addr   <= bank_nxt;
            flag_rd_end <= flag_nxt;
            in_rd_q     <= in_rd_nxt;
            last_q      <= last_nxt;
        end
    end

    // in_rd_q spans exactly the beats of each issued RD; delay it by CAS latency to find DQ.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            vld_pipe    <= '0;
            last_pipe   <= '0;
            rd_data     <= '0;
            rd_data_vld <= 1'b0;
            rd_done     <= 1'b0;
            rd_busy     <= 1'b0;
        end else begin
            vld_pipe    <= {vld_pipe[CAS_LAT-2:0], in_rd_q};
            last_pipe   <= {last_pipe[CAS_LAT-2:0], last_q};
            rd_data     <= sdram_dq_in;
            rd_data_vld <= vld_pipe[CAS_LAT-1];
            rd_done     <= last_pipe[CAS_LAT-1];
            if (accept) begin
                rd_busy <= 1'b1;
            end else if (rd_done) begin
                rd_busy <= 1'b0;
            end
        end
    end

endmodule
